// File: rtl/wb_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module   : wb_commit_unit
//  Purpose  : Writeback commit stage. Buffers the no-backpressure writeback
//             stream, drains it into the GPR write port, pulses a scoreboard
//             release on every end-of-packet and checks per-warp sop/eop
//             framing. Optional perf counters under WB_COMMIT_PERF_EN.
//  Revision : 1.0  initial release
// ============================================================================
module wb_commit_unit #(
    parameter int NUM_THREADS = 4,
    parameter int ISSUE_WIS_W = 2,
    parameter int NR_BITS     = 6,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = 44,
    parameter int PC_WIDTH    = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        wb_valid,
    input  logic [UUID_WIDTH-1:0]       wb_uuid,
    input  logic [ISSUE_WIS_W-1:0]      wb_wis,
    input  logic [NUM_THREADS-1:0]      wb_tmask,
    input  logic [PC_WIDTH-1:0]         wb_pc,
    input  logic [NR_BITS-1:0]          wb_rd,
    input  logic [NUM_THREADS*XLEN-1:0] wb_data,
    input  logic                        wb_sop,
    input  logic                        wb_eop,

    output logic                        gpr_wr_valid,
    input  logic                        gpr_wr_ready,
    output logic [ISSUE_WIS_W-1:0]      gpr_wr_wis,
    output logic [NR_BITS-1:0]          gpr_wr_rd,
    output logic [NUM_THREADS-1:0]      gpr_wr_tmask,
    output logic [NUM_THREADS*XLEN-1:0] gpr_wr_data,

    output logic                        sb_rel_valid,
    output logic [ISSUE_WIS_W-1:0]      sb_rel_wis,
    output logic [NR_BITS-1:0]          sb_rel_rd,

    output logic                        overflow,
    output logic                        proto_err,
    output logic [31:0]                 perf_commits,
    output logic [31:0]                 perf_stalls
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int NUM_WARPS = 1 << ISSUE_WIS_W;
    localparam int DATA_W    = NUM_THREADS * XLEN;
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(FIFO_DEPTH);

    logic [ISSUE_WIS_W-1:0] r_mem_wis   [FIFO_DEPTH];
    logic [NR_BITS-1:0]     r_mem_rd    [FIFO_DEPTH];
    logic [NUM_THREADS-1:0] r_mem_tmask [FIFO_DEPTH];
    logic [DATA_W-1:0]      r_mem_data  [FIFO_DEPTH];
    logic                   r_mem_eop   [FIFO_DEPTH];

    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic                   r_rel_valid;
    logic [ISSUE_WIS_W-1:0] r_rel_wis;
    logic [NR_BITS-1:0]     r_rel_rd;
    logic                   r_overflow;
    logic                   r_proto_err;
    logic [NUM_WARPS-1:0]   r_inflight;

    logic w_head_present;
    logic w_head_writable;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_frame_err;

    // uuid and pc are carried only for debug visibility
    logic w_unused_ok;
    assign w_unused_ok = ^{wb_uuid, wb_pc};

    assign w_head_present  = (r_count != '0);
    assign w_head_writable = w_head_present && (r_mem_tmask[r_rd_ptr] != '0)
                                            && (r_mem_rd[r_rd_ptr] != '0);
    assign w_full          = (r_count == c_full_cnt);
    // Non-writable heads retire on their own; writable ones wait for the handshake.
    assign w_pop           = w_head_present && (!w_head_writable || gpr_wr_ready);
    assign w_push          = wb_valid && (!w_full || w_pop);
    assign w_drop          = wb_valid && w_full && !w_pop;
    assign w_frame_err     = wb_valid && (wb_sop == r_inflight[wb_wis]);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_wis[r_wr_ptr]   <= wb_wis;
            r_mem_rd[r_wr_ptr]    <= wb_rd;
            r_mem_tmask[r_wr_ptr] <= wb_tmask;
            r_mem_data[r_wr_ptr]  <= wb_data;
            r_mem_eop[r_wr_ptr]   <= wb_eop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rel_valid <= 1'b0;
            r_rel_wis   <= '0;
            r_rel_rd    <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
            r_inflight  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_pop && r_mem_eop[r_rd_ptr]) begin
                r_rel_valid <= 1'b1;
                r_rel_wis   <= r_mem_wis[r_rd_ptr];
                r_rel_rd    <= r_mem_rd[r_rd_ptr];
            end else begin
                r_rel_valid <= 1'b0;
                r_rel_wis   <= '0;
                r_rel_rd    <= '0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_frame_err) begin
                r_proto_err <= 1'b1;
            end
            // eop takes priority so a single-packet instruction leaves the warp idle
            if (wb_valid) begin
                if (wb_eop) begin
                    r_inflight[wb_wis] <= 1'b0;
                end else if (wb_sop) begin
                    r_inflight[wb_wis] <= 1'b1;
                end
            end
        end
    end

    assign gpr_wr_valid = w_head_writable;
    assign gpr_wr_wis   = w_head_present ? r_mem_wis[r_rd_ptr]   : '0;
    assign gpr_wr_rd    = w_head_present ? r_mem_rd[r_rd_ptr]    : '0;
    assign gpr_wr_tmask = w_head_present ? r_mem_tmask[r_rd_ptr] : '0;
    assign gpr_wr_data  = w_head_present ? r_mem_data[r_rd_ptr]  : '0;

    assign sb_rel_valid = r_rel_valid;
    assign sb_rel_wis   = r_rel_wis;
    assign sb_rel_rd    = r_rel_rd;
    assign overflow     = r_overflow;
    assign proto_err    = r_proto_err;

`ifdef WB_COMMIT_PERF_EN
    logic [31:0] r_perf_commits;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_commits <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (gpr_wr_valid && gpr_wr_ready) begin
                r_perf_commits <= r_perf_commits + 32'd1;
            end
            if (gpr_wr_valid && !gpr_wr_ready) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_commits = r_perf_commits;
    assign perf_stalls  = r_perf_stalls;
`else
    assign perf_commits = '0;
    assign perf_stalls  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_commit_unit
//  Purpose  : Scoreboard bench for wb_commit_unit: directed scenarios followed
//             by random traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_commit_unit;

    localparam int NT    = 4;
    localparam int WISW  = 2;
    localparam int NRB   = 6;
    localparam int XL    = 32;
    localparam int UW    = 44;
    localparam int PCW   = 32;
    localparam int DEPTH = 4;
    localparam int DW    = NT * XL;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           wb_valid = 1'b0;
    logic [UW-1:0]  wb_uuid = '0;
    logic [WISW-1:0] wb_wis = '0;
    logic [NT-1:0]  wb_tmask = '0;
    logic [PCW-1:0] wb_pc = '0;
    logic [NRB-1:0] wb_rd = '0;
    logic [DW-1:0]  wb_data = '0;
    logic           wb_sop = 1'b0;
    logic           wb_eop = 1'b0;
    logic           gpr_wr_valid;
    logic           gpr_wr_ready = 1'b0;
    logic [WISW-1:0] gpr_wr_wis;
    logic [NRB-1:0] gpr_wr_rd;
    logic [NT-1:0]  gpr_wr_tmask;
    logic [DW-1:0]  gpr_wr_data;
    logic           sb_rel_valid;
    logic [WISW-1:0] sb_rel_wis;
    logic [NRB-1:0] sb_rel_rd;
    logic           overflow;
    logic           proto_err;
    logic [31:0]    perf_commits;
    logic [31:0]    perf_stalls;

    always #5 clk = ~clk;

    wb_commit_unit #(
        .NUM_THREADS(NT), .ISSUE_WIS_W(WISW), .NR_BITS(NRB), .XLEN(XL),
        .UUID_WIDTH(UW), .PC_WIDTH(PCW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wis(wb_wis), .wb_tmask(wb_tmask),
        .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .wb_sop(wb_sop), .wb_eop(wb_eop),
        .gpr_wr_valid(gpr_wr_valid), .gpr_wr_ready(gpr_wr_ready), .gpr_wr_wis(gpr_wr_wis),
        .gpr_wr_rd(gpr_wr_rd), .gpr_wr_tmask(gpr_wr_tmask), .gpr_wr_data(gpr_wr_data),
        .sb_rel_valid(sb_rel_valid), .sb_rel_wis(sb_rel_wis), .sb_rel_rd(sb_rel_rd),
        .overflow(overflow), .proto_err(proto_err),
        .perf_commits(perf_commits), .perf_stalls(perf_stalls)
    );

    typedef struct packed {
        logic [WISW-1:0] wis;
        logic [NRB-1:0]  rd;
        logic [NT-1:0]   tmask;
        logic [DW-1:0]   data;
        logic            eop;
    } ent_t;

    typedef struct packed {
        logic [WISW-1:0] wis;
        logic [NRB-1:0]  rd;
    } rel_t;

    ent_t m_fifo[$];
    ent_t exp_wr[$];
    rel_t exp_rel[$];
    logic [3:0]  m_inflight = '0;
    bit          m_ovf = 0;
    bit          m_perr = 0;
    int unsigned m_commits = 0;
    int unsigned m_stalls = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    ent_t m_head;
    ent_t m_new;
    rel_t m_rel;
    bit   m_expv;
    bit   m_pop;
    ent_t mon_w;
    rel_t mon_r;

    logic [3:0] tb_inf = '0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of buffered packets, checked then advanced each cycle.
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outputs",
                160'({gpr_wr_valid, gpr_wr_wis, gpr_wr_rd, gpr_wr_tmask, gpr_wr_data,
                      sb_rel_valid, sb_rel_wis, sb_rel_rd, overflow, proto_err}), 160'd0);
            chk("reset_perf", 160'({perf_commits, perf_stalls}), 160'd0);
            m_fifo.delete();
            exp_wr.delete();
            exp_rel.delete();
            m_inflight = '0;
            m_ovf      = 0;
            m_perr     = 0;
            m_commits  = 0;
            m_stalls   = 0;
        end else begin
            m_expv = 0;
            if (m_fifo.size() != 0) begin
                m_head = m_fifo[0];
                m_expv = (m_head.tmask != '0) && (m_head.rd != '0);
            end
            chk("gpr_valid", 160'(gpr_wr_valid), 160'(m_expv));
            if (m_expv) begin
                chk("gpr_payload", 160'({gpr_wr_wis, gpr_wr_rd, gpr_wr_tmask, gpr_wr_data}),
                    160'({m_head.wis, m_head.rd, m_head.tmask, m_head.data}));
            end
            chk("overflow", 160'(overflow), 160'(m_ovf));
            chk("proto_err", 160'(proto_err), 160'(m_perr));
`ifdef WB_COMMIT_PERF_EN
            chk("perf_commits", 160'(perf_commits), 160'(m_commits));
            chk("perf_stalls", 160'(perf_stalls), 160'(m_stalls));
`else
            chk("perf_tied", 160'({perf_commits, perf_stalls}), 160'd0);
`endif
            m_pop = (m_fifo.size() != 0) && (!m_expv || gpr_wr_ready);
            if (m_expv && gpr_wr_ready)  m_commits++;
            if (m_expv && !gpr_wr_ready) m_stalls++;
            if (wb_valid) begin
                if (wb_sop == m_inflight[wb_wis]) m_perr = 1;
                if (wb_eop)      m_inflight[wb_wis] = 1'b0;
                else if (wb_sop) m_inflight[wb_wis] = 1'b1;
                if (m_fifo.size() < DEPTH || m_pop) begin
                    m_new.wis   = wb_wis;
                    m_new.rd    = wb_rd;
                    m_new.tmask = wb_tmask;
                    m_new.data  = wb_data;
                    m_new.eop   = wb_eop;
                    m_fifo.push_back(m_new);
                    if (wb_tmask != '0 && wb_rd != '0) exp_wr.push_back(m_new);
                    if (wb_eop) begin
                        m_rel.wis = wb_wis;
                        m_rel.rd  = wb_rd;
                        exp_rel.push_back(m_rel);
                    end
                end else begin
                    m_ovf = 1;
                end
            end
            if (m_pop) void'(m_fifo.pop_front());
        end
    end

    // Scoreboard monitor: consumes expectations whenever the DUT produces a write or release.
    always @(negedge clk) begin
        if (!reset) begin
            if (gpr_wr_valid && gpr_wr_ready) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL gpr_unexpected: got write wis=%0d rd=%0d, required none at %0t",
                             gpr_wr_wis, gpr_wr_rd, $time);
                end else begin
                    mon_w = exp_wr.pop_front();
                    chk("gpr_write", 160'({gpr_wr_wis, gpr_wr_rd, gpr_wr_tmask, gpr_wr_data}),
                        160'({mon_w.wis, mon_w.rd, mon_w.tmask, mon_w.data}));
                end
            end
            if (sb_rel_valid) begin
                if (exp_rel.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rel_unexpected: got release wis=%0d rd=%0d, required none at %0t",
                             sb_rel_wis, sb_rel_rd, $time);
                end else begin
                    mon_r = exp_rel.pop_front();
                    chk("sb_release", 160'({sb_rel_wis, sb_rel_rd}), 160'({mon_r.wis, mon_r.rd}));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        wb_valid = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic do_reset(input int n);
        wb_valid = 1'b0;
        reset    = 1'b1;
        tb_inf   = '0;
        repeat (n) next_cycle();
        reset = 1'b0;
    endtask

    task automatic drive(input logic [WISW-1:0] wis, input logic [NRB-1:0] rd,
                         input logic [NT-1:0] tm, input logic [DW-1:0] d,
                         input logic sop, input logic eop);
        wb_valid = 1'b1;
        wb_uuid  = UW'({$urandom, $urandom});
        wb_pc    = $urandom;
        wb_wis   = wis;
        wb_rd    = rd;
        wb_tmask = tm;
        wb_data  = d;
        wb_sop   = sop;
        wb_eop   = eop;
        next_cycle();
        wb_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [WISW-1:0] r_w;
    logic [NRB-1:0]  r_rd;
    logic [NT-1:0]   r_tm;
    logic            r_sop;
    logic            r_eop;

    initial begin
        repeat (3) next_cycle();
        reset = 1'b0;
        next_cycle();

        // single packet, sop=eop
        gpr_wr_ready = 1'b1;
        drive(2'd1, 6'd5, 4'b1011, {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, 1'b1, 1'b1);
        idle(4);

        // three-packet instruction held off by the register file
        gpr_wr_ready = 1'b0;
        drive(2'd2, 6'd7, 4'hF, rnd_data(), 1'b1, 1'b0);
        drive(2'd2, 6'd7, 4'h3, rnd_data(), 1'b0, 1'b0);
        drive(2'd2, 6'd7, 4'hC, rnd_data(), 1'b0, 1'b1);
        idle(2);
        gpr_wr_ready = 1'b1;
        idle(6);

        // rd=0 packet: no write, release only
        drive(2'd0, 6'd0, 4'hF, rnd_data(), 1'b1, 1'b1);
        idle(4);

        // overflow: 5 packets into a 4-deep FIFO
        gpr_wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive(2'd3, NRB'(10 + i), 4'hF, rnd_data(), 1'b1, 1'b1);
        idle(1);
        chk("overflow_sticky", 160'(overflow), 160'd1);
        gpr_wr_ready = 1'b1;
        idle(8);

        // double sop on warp 0
        do_reset(2);
        drive(2'd0, 6'd9, 4'h1, rnd_data(), 1'b1, 1'b0);
        drive(2'd0, 6'd9, 4'h2, rnd_data(), 1'b1, 1'b1);
        idle(3);
        chk("proto_double_sop", 160'(proto_err), 160'd1);

        // continuation without sop on warp 3 after reset
        do_reset(2);
        drive(2'd3, 6'd4, 4'h8, rnd_data(), 1'b0, 1'b1);
        idle(3);
        chk("proto_missing_sop", 160'(proto_err), 160'd1);

        // reset with three buffered entries
        do_reset(2);
        gpr_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(2'd1, NRB'(20 + i), 4'hF, rnd_data(), 1'b1, 1'b1);
        do_reset(1);
        gpr_wr_ready = 1'b1;
        idle(6);

        // random traffic with legal framing and rare injected violations
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            gpr_wr_ready = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 55) begin
                r_w   = WISW'($urandom_range(0, 3));
                r_sop = !tb_inf[r_w];
                if ($urandom_range(0, 99) < 2) r_sop = !r_sop;
                r_eop = ($urandom_range(0, 2) == 0);
                r_rd  = ($urandom_range(0, 7) == 0) ? '0 : NRB'($urandom_range(1, 63));
                r_tm  = ($urandom_range(0, 7) == 0) ? '0 : NT'($urandom_range(0, 15));
                if (r_eop)      tb_inf[r_w] = 1'b0;
                else if (r_sop) tb_inf[r_w] = 1'b1;
                drive(r_w, r_rd, r_tm, rnd_data(), r_sop, r_eop);
            end else begin
                idle(1);
            end
            if (c == 1500) do_reset(2);
        end

        gpr_wr_ready = 1'b1;
        idle(12);
        chk("drain_writes", 160'(exp_wr.size()), 160'd0);
        chk("drain_releases", 160'(exp_rel.size()), 160'd0);
        chk("drain_fifo", 160'(m_fifo.size()), 160'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
